// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use/RAW/WAW stall generation and a scoreboard of outstanding long-latency writes.
// Optional performance counters are built when FWD_PERF_CNT_EN is defined.

module fwd_port_mux #(
   parameter int XLEN = 32,
   parameter int RAW  = 5,
   parameter int NSTG = 2
) (
   input  logic [RAW-1:0]       rs,
   input  logic [NSTG*RAW-1:0]  stgRd,
   input  logic [NSTG-1:0]      stgRw,
   input  logic [NSTG*XLEN-1:0] stgData,
   input  logic [XLEN-1:0]      rfData,
   output logic [XLEN-1:0]      data,
   output logic                 hit
);
   // Walk oldest to youngest so the youngest matching stage overrides.
   always_comb begin
      data = rfData;
      hit  = 1'b0;
      for (int s = NSTG-1; s >= 0; s--) begin
         if (stgRw[s] && stgRd[s*RAW +: RAW] == rs && rs != '0) begin
            data = stgData[s*XLEN +: XLEN];
            hit  = 1'b1;
         end
      end
   end
endmodule

module fwd_hazard_unit #(
   parameter int XLEN     = 32,
   parameter int RAW      = 5,
   parameter int NRD      = 2,
   parameter int NSTG     = 2,
   parameter int MAX_PEND = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NRD*RAW-1:0]   id_rs,
   input  logic [NRD-1:0]       id_rs_vld,
   input  logic [RAW-1:0]       id_rd,
   input  logic                 id_rd_vld,
   input  logic [RAW-1:0]       ex_rd,
   input  logic                 ex_rw,
   input  logic                 ex_is_load,
   input  logic [NSTG*RAW-1:0]  stg_rd,
   input  logic [NSTG-1:0]      stg_rw,
   input  logic [NSTG*XLEN-1:0] stg_data,
   input  logic [NRD*XLEN-1:0]  rf_rdata,
   input  logic                 lat_issue,
   input  logic [RAW-1:0]       lat_issue_rd,
   input  logic                 lat_done,
   input  logic [RAW-1:0]       lat_done_rd,
   output logic [NRD*XLEN-1:0]  fwd_data,
   output logic [NRD-1:0]       fwd_hit,
   output logic                 stall,
   output logic                 pend_full,
`ifdef FWD_PERF_CNT_EN
   output logic [31:0]          perf_fwd_cnt,
   output logic [31:0]          perf_stall_cnt,
`endif
   output logic                 sb_err
);
   localparam int NREG = 1 << RAW;
   localparam int CNTW = $clog2(MAX_PEND+1);

   logic [NREG-1:0] pend, pendNext;
   logic [CNTW-1:0] pendCnt;
   logic loadUse, rawStall, wawStall;
   logic issueOk, doneOk, issueAccept, sbViol;

   for (genvar p = 0; p < NRD; p++) begin : gPort
      fwd_port_mux #(.XLEN(XLEN), .RAW(RAW), .NSTG(NSTG)) uMux (
         .rs      (id_rs[p*RAW +: RAW]),
         .stgRd   (stg_rd),
         .stgRw   (stg_rw),
         .stgData (stg_data),
         .rfData  (rf_rdata[p*XLEN +: XLEN]),
         .data    (fwd_data[p*XLEN +: XLEN]),
         .hit     (fwd_hit[p])
      );
   end

   always_comb begin
      loadUse  = 1'b0;
      rawStall = 1'b0;
      for (int p = 0; p < NRD; p++) begin
         if (id_rs_vld[p]) begin
            if (ex_rw && ex_is_load && ex_rd != '0 && id_rs[p*RAW +: RAW] == ex_rd)
               loadUse = 1'b1;
            if (pend[id_rs[p*RAW +: RAW]])
               rawStall = 1'b1;
         end
      end
   end

   assign wawStall  = id_rd_vld && id_rd != '0 && pend[id_rd];
   assign stall     = loadUse | rawStall | wawStall;
   assign pend_full = (pendCnt == CNTW'(MAX_PEND));

   // A same-cycle completion frees a slot, and re-issuing to the rd that completes is legal.
   assign issueOk     = lat_issue && lat_issue_rd != '0;
   assign doneOk      = lat_done && lat_done_rd != '0 && pend[lat_done_rd];
   assign issueAccept = issueOk
                        && (!pend[lat_issue_rd] || (doneOk && lat_done_rd == lat_issue_rd))
                        && (!pend_full || doneOk);
   assign sbViol      = (lat_done && !doneOk) || (issueOk && !issueAccept);

   always_comb begin
      pendNext = pend;
      if (doneOk)      pendNext[lat_done_rd]  = 1'b0;
      if (issueAccept) pendNext[lat_issue_rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend    <= '0;
         pendCnt <= '0;
         sb_err  <= 1'b0;
      end else begin
         pend    <= pendNext;
         pendCnt <= pendCnt + CNTW'(issueAccept) - CNTW'(doneOk);
         if (sbViol) sb_err <= 1'b1;
      end
   end

`ifdef FWD_PERF_CNT_EN
   logic [31:0] fwdInc;

   always_comb begin
      fwdInc = '0;
      for (int p = 0; p < NRD; p++)
         fwdInc = fwdInc + 32'(fwd_hit[p] & id_rs_vld[p]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fwd_cnt   <= '0;
         perf_stall_cnt <= '0;
      end else if (stall) begin
         perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end else begin
         perf_fwd_cnt   <= perf_fwd_cnt + fwdInc;
      end
   end
`endif
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the single-pair forwarding mux.
- Forwards to NRD read ports from NSTG in-flight writeback stages, with youngest-stage priority.
- Generates load-use stalls.
- Holds a scoreboard of outstanding long-latency writes (MUL/DIV) that drives RAW/WAW stalls.
- Sits between ID/EX pipeline registers and the EX operand muxes; the stall output feeds the PC/IF/ID hold logic.

Parameters:
- XLEN, 32, data width.
- RAW, 5, register address width (2^RAW architectural registers; x0 hardwired zero).
- NRD, 2, number of operand read ports.
- NSTG, 2, forwarding source stages; index 0 = youngest (EX/MEM), NSTG-1 = oldest (MEM/WB).
- MAX_PEND, 4, maximum outstanding long-latency writes.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- id_rs  in  NRD*RAW  source register addresses of the instruction in ID; port p at [p*RAW +: RAW].
- id_rs_vld  in  NRD  port p actually reads its register.
- id_rd  in  RAW  destination register of the ID instruction.
- id_rd_vld  in  1  ID instruction writes id_rd.
- ex_rd  in  RAW  destination register of the instruction in EX.
- ex_rw  in  1  EX instruction writes a register.
- ex_is_load  in  1  EX instruction is a load.
- stg_rd  in  NSTG*RAW  destination address per forwarding stage.
- stg_rw  in  NSTG  write enable per stage.
- stg_data  in  NSTG*XLEN  final writeback value per stage (load/ALU select already resolved upstream).
- rf_rdata  in  NRD*XLEN  register-file/ID-EX operand values (no-hazard path).
- lat_issue  in  1  long-latency op issued this cycle.
- lat_issue_rd  in  RAW  its destination.
- lat_done  in  1  long-latency op completes this cycle.
- lat_done_rd  in  RAW  its destination.
- fwd_data  out  NRD*XLEN  resolved operand per port.
- fwd_hit  out  NRD  port p taken from a stage rather than rf_rdata.
- stall  out  1  hold IF/ID and insert a bubble into EX.
- pend_full  out  1  scoreboard count == MAX_PEND.
- sb_err  out  1  sticky protocol-violation flag.

Behaviour:
- Forwarding (combinational, zero latency), per port p:
  - Select the lowest stage index s with stg_rw[s] & stg_rd[s]==id_rs[p] & stg_rd[s]!=0.
  - Hit: fwd_data[p]=stg_data[s], fwd_hit[p]=1.
  - No hit: fwd_data[p]=rf_rdata[p], fwd_hit[p]=0.
  - id_rs==0 never hits.
  - id_rs_vld does not gate forwarding; it only affects stall.
- Load-use stall: ex_rw & ex_is_load & ex_rd!=0 & (any p with id_rs_vld[p] & id_rs[p]==ex_rd).
- Scoreboard:
  - pend[2^RAW-1:0] bitmap and pend_cnt (width clog2(MAX_PEND+1)), both registered.
  - Reset: pend=0, pend_cnt=0, sb_err=0.
- Scoreboard update at each rising edge:
  - lat_issue with lat_issue_rd!=0 sets its bit and increments pend_cnt.
  - lat_done with a pending lat_done_rd clears its bit and decrements pend_cnt.
  - Both in one cycle: count unchanged. Same rd on both: bit ends set (issue wins).
  - lat_issue_rd==0: ignored, no count change.
  - lat_done_rd==0 or not pending: no state change, sb_err set.
- RAW stall: any valid port whose id_rs bit is set in the registered pend.
- WAW stall: id_rd_vld & id_rd!=0 & pend[id_rd].
- Done-cycle rule: a lat_done bit clears at the next edge, so the RAW/WAW stall holds through the done cycle. The result is then forwarded via stg_*.
- stall is the OR of load-use, RAW and WAW stalls; combinational.
- pend_full is registered-derived: pend_cnt==MAX_PEND.
- Issue while full:
  - Without a same-cycle done: ignored, no state change, sb_err set.
  - With a same-cycle done: legal.
- Issue to an already-pending rd without a same-cycle done of that rd: sb_err set, bit stays set, count unchanged.
- sb_err clears only on reset.
- Pipeline flush does not affect the scoreboard; in-flight ops still complete.
- Reset mid-operation clears all state immediately (asynchronous). Outputs then follow the combinational rules with pend=0.

Optional Feature:
- Macro FWD_PERF_CNT_EN. When defined, add outputs:
  - perf_fwd_cnt (32b): increments by popcount(fwd_hit & id_rs_vld) each cycle stall==0.
  - perf_stall_cnt (32b): increments each cycle stall==1.
- Both counters wrap at 2^32 and reset to 0.
- When undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Dual-stage priority: stg0 rd=5 data=0xAAAA, stg1 rd=5 data=0xBBBB, id_rs[0]=5 -> fwd_data[0]=0xAAAA, fwd_hit[0]=1. Drop stg_rw[0] -> 0xBBBB.
- x0 guard: all stages rd=0 rw=1 data=0xFFFFFFFF, id_rs=0, rf_rdata=0 -> fwd_data=0, fwd_hit=0, stall=0.
- Load-use: ex_is_load=1, ex_rw=1, ex_rd=7, id_rs[1]=7 vld -> stall=1. With id_rs_vld[1]=0 -> stall=0.
- Scoreboard RAW: issue rd=9, next cycle id_rs[0]=9 -> stall=1 until the cycle after lat_done rd=9; pend_cnt 0->1->0.
- Full/simultaneous: issue 4 distinct rds -> pend_full=1. Issue rd=12 + done rd=3 in the same cycle -> pend_full stays 1, sb_err=0. A further lone issue -> sb_err=1, state unchanged.
- Reset mid-op: 3 pending, assert rst_n=0 asynchronously -> pend_cnt=0, pend_full=0, sb_err=0, stall=0 before the next clock edge.
